// File: rtl/halfbridge_monitor.sv
// Gate-drive readback monitor for a complementary half-bridge gate pair.
// Measures high time, period and both dead times per PWM period; flags overlap and timeout.

module halfbridge_monitor #(
   parameter int CNT_W      = 11,
   parameter int PERIOD_MAX = 2047
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ce,
   input  logic             s,
   input  logic             nots,
   input  logic             clr_fault,
   output logic [9:0]       d_meas,
   output logic [CNT_W-1:0] per_meas,
   output logic [7:0]       dt_on,
   output logic [7:0]       dt_off,
   output logic             meas_valid,
   output logic             fault_overlap,
   output logic             fault_timeout,
   output logic [2:0]       dbg_state
);

   typedef enum logic [2:0] {
      ST_WAIT_SYNC = 3'd0,
      ST_ON        = 3'd1,
      ST_DT_OFF    = 3'd2,
      ST_OFF       = 3'd3,
      ST_DT_ON     = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] L_CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] L_CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] L_PER_MAX = CNT_W'(PERIOD_MAX);
   localparam logic [CNT_W-1:0] L_D_SAT   = CNT_W'(1023);

   // Synchronizers and per-tick previous samples
   logic r_s_meta;
   logic r_s_sync;
   logic r_n_meta;
   logic r_n_sync;
   logic r_s_prev;
   logic r_n_prev;

   // FSM and measurement counters
   state_t           r_state;
   state_t           w_state_nx;
   logic [CNT_W-1:0] r_period_cnt;
   logic [CNT_W-1:0] w_period_nx;
   logic [CNT_W-1:0] r_high_cnt;
   logic [CNT_W-1:0] w_high_nx;
   logic [7:0]       r_dt_off_cnt;
   logic [7:0]       w_dt_off_nx;
   logic [7:0]       r_dt_on_cnt;
   logic [7:0]       w_dt_on_nx;
   logic             w_period_end;
   logic             w_ov_set;
   logic             w_to_set;

   // Latched outputs
   logic [9:0]       r_d_meas;
   logic [CNT_W-1:0] r_per_meas;
   logic [7:0]       r_dt_on_meas;
   logic [7:0]       r_dt_off_meas;
   logic             r_meas_valid;
   logic             r_fault_ov;
   logic             r_fault_to;

   logic             w_s;
   logic             w_n;
   logic             w_s_rise;
   logic             w_n_rise;
   logic             w_n_fall;
   logic [CNT_W-1:0] w_period_inc;
   logic [CNT_W-1:0] w_high_inc;
   logic [7:0]       w_dt_off_inc;
   logic [7:0]       w_dt_on_inc;
   logic [9:0]       w_d_sat;

   assign w_s      = r_s_sync;
   assign w_n      = r_n_sync;
   assign w_s_rise = w_s & ~r_s_prev;
   assign w_n_rise = w_n & ~r_n_prev;
   assign w_n_fall = ~w_n & r_n_prev;

   // period_cnt is bounded by the timeout check, so a plain increment cannot wrap
   assign w_period_inc = r_period_cnt + L_CNT_ONE;
   assign w_high_inc   = (r_high_cnt == L_CNT_MAX) ? r_high_cnt : r_high_cnt + L_CNT_ONE;
   assign w_dt_off_inc = (r_dt_off_cnt == 8'hFF) ? r_dt_off_cnt : r_dt_off_cnt + 8'd1;
   assign w_dt_on_inc  = (r_dt_on_cnt == 8'hFF) ? r_dt_on_cnt : r_dt_on_cnt + 8'd1;
   assign w_d_sat      = (r_high_cnt > L_D_SAT) ? 10'd1023 : r_high_cnt[9:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s_meta <= 1'b0;
         r_s_sync <= 1'b0;
         r_n_meta <= 1'b0;
         r_n_sync <= 1'b0;
         r_s_prev <= 1'b0;
         r_n_prev <= 1'b0;
      end else begin
         r_s_meta <= s;
         r_s_sync <= r_s_meta;
         r_n_meta <= nots;
         r_n_sync <= r_n_meta;
         if (ce) begin
            r_s_prev <= r_s_sync;
            r_n_prev <= r_n_sync;
         end
      end
   end

   always_comb begin
      w_state_nx   = r_state;
      w_period_nx  = r_period_cnt;
      w_high_nx    = r_high_cnt;
      w_dt_off_nx  = r_dt_off_cnt;
      w_dt_on_nx   = r_dt_on_cnt;
      w_period_end = 1'b0;
      w_ov_set     = 1'b0;
      w_to_set     = 1'b0;
      if (ce) begin
         if (w_s && w_n) begin
            w_ov_set    = 1'b1;
            w_state_nx  = ST_WAIT_SYNC;
            w_period_nx = '0;
            w_high_nx   = '0;
            w_dt_off_nx = '0;
            w_dt_on_nx  = '0;
         end else begin
            case (r_state)
               ST_WAIT_SYNC: begin
                  if (w_s_rise) begin
                     w_state_nx  = ST_ON;
                     w_period_nx = L_CNT_ONE;
                     w_high_nx   = L_CNT_ONE;
                     w_dt_off_nx = '0;
                     w_dt_on_nx  = '0;
                  end
               end
               ST_ON: begin
                  w_period_nx = w_period_inc;
                  if (w_s) begin
                     w_high_nx = w_high_inc;
                  end else if (w_n) begin
                     w_state_nx  = ST_OFF;
                     w_dt_off_nx = '0;
                  end else begin
                     w_state_nx  = ST_DT_OFF;
                     w_dt_off_nx = 8'd1;
                  end
               end
               ST_DT_OFF: begin
                  if (w_s_rise) begin
                     w_period_end = 1'b1;
                  end else begin
                     w_period_nx = w_period_inc;
                     if (w_n_rise) w_state_nx = ST_OFF;
                     else          w_dt_off_nx = w_dt_off_inc;
                  end
               end
               ST_OFF: begin
                  // An S rise straight out of OFF means zero on-side dead time
                  if (w_s_rise) begin
                     w_period_end = 1'b1;
                  end else begin
                     w_period_nx = w_period_inc;
                     if (w_n_fall) begin
                        w_state_nx = ST_DT_ON;
                        w_dt_on_nx = 8'd1;
                     end
                  end
               end
               ST_DT_ON: begin
                  if (w_s_rise) begin
                     w_period_end = 1'b1;
                  end else begin
                     w_period_nx = w_period_inc;
                     if (w_n) w_state_nx = ST_OFF;
                     else     w_dt_on_nx = w_dt_on_inc;
                  end
               end
               default: begin
                  w_state_nx = ST_WAIT_SYNC;
               end
            endcase

            if (w_period_end) begin
               w_state_nx  = ST_ON;
               w_period_nx = L_CNT_ONE;
               w_high_nx   = L_CNT_ONE;
               w_dt_off_nx = '0;
               w_dt_on_nx  = '0;
            end else if (r_state != ST_WAIT_SYNC && r_period_cnt == L_PER_MAX) begin
               w_to_set    = 1'b1;
               w_state_nx  = ST_WAIT_SYNC;
               w_period_nx = '0;
               w_high_nx   = '0;
               w_dt_off_nx = '0;
               w_dt_on_nx  = '0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_WAIT_SYNC;
         r_period_cnt <= '0;
         r_high_cnt   <= '0;
         r_dt_off_cnt <= '0;
         r_dt_on_cnt  <= '0;
      end else begin
         r_state      <= w_state_nx;
         r_period_cnt <= w_period_nx;
         r_high_cnt   <= w_high_nx;
         r_dt_off_cnt <= w_dt_off_nx;
         r_dt_on_cnt  <= w_dt_on_nx;
      end
   end

   // A fault raised on the same cycle as clr_fault stays set
   always_ff @(posedge clk) begin
      if (rst) begin
         r_d_meas      <= '0;
         r_per_meas    <= '0;
         r_dt_on_meas  <= '0;
         r_dt_off_meas <= '0;
         r_meas_valid  <= 1'b0;
         r_fault_ov    <= 1'b0;
         r_fault_to    <= 1'b0;
      end else begin
         r_meas_valid <= 1'b0;
         if (w_period_end) begin
            r_d_meas      <= w_d_sat;
            r_per_meas    <= r_period_cnt;
            r_dt_on_meas  <= r_dt_on_cnt;
            r_dt_off_meas <= r_dt_off_cnt;
            r_meas_valid  <= 1'b1;
         end
         if (w_ov_set)       r_fault_ov <= 1'b1;
         else if (clr_fault) r_fault_ov <= 1'b0;
         if (w_to_set)       r_fault_to <= 1'b1;
         else if (clr_fault) r_fault_to <= 1'b0;
      end
   end

   assign d_meas        = r_d_meas;
   assign per_meas      = r_per_meas;
   assign dt_on         = r_dt_on_meas;
   assign dt_off        = r_dt_off_meas;
   assign meas_valid    = r_meas_valid;
   assign fault_overlap = r_fault_ov;
   assign fault_timeout = r_fault_to;
   assign dbg_state     = r_state;

endmodule
